// File: rtl/lnvd_view_nsig_capture.sv
// Per-channel peak monitor with a 3-digit hex display: shows the live, max, min or
// peak-to-peak value of a switch-selected channel, refreshed periodically or on selection change.
module lnvd_view_nsig_capture #(
    parameter int NUM_CH      = 8,
    parameter int DATA_W      = 12,
    parameter int REFRESH_DIV = 5000000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [9:0]               SW_in,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    output logic [7:0]               HEX1_in,
    output logic [7:0]               HEX2_in,
    output logic [7:0]               HEX3_in
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [9:0]       sw_meta_q;
    logic [9:0]       sw_sync_q;
    logic [3:0]       sel_prev_q;
    logic [1:0]       mode_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [11:0]      max_q [NUM_CH];
    logic [11:0]      min_q [NUM_CH];
    logic [NUM_CH-1:0] valid_q;
    logic [11:0]      disp_q;
    logic             dash_q;
    logic [7:0]       hex1_q;
    logic [7:0]       hex2_q;
    logic [7:0]       hex3_q;

    logic [3:0]       sel_s;
    logic [1:0]       mode_s;
    logic             freeze_s;
    logic             clear_s;
    logic [11:0]      sample_s [NUM_CH];
    logic [11:0]      sel_live_s;
    logic [11:0]      sel_max_s;
    logic [11:0]      sel_min_s;
    logic             sel_valid_s;
    logic             sel_in_range_s;
    logic [11:0]      disp_d;
    logic             change_s;
    logic             tick_s;
    logic             load_s;

    // Active-low 7-segment glyphs for 0-F, bit 6 = g ... bit 0 = a
    function automatic logic [6:0] hex_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            4'hF:    s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign sel_s    = sw_sync_q[3:0];
    assign mode_s   = sw_sync_q[5:4];
    assign freeze_s = sw_sync_q[6];
    assign clear_s  = sw_sync_q[7];

    // Unpack channel samples and zero-extend to display width
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            sample_s[k] = 12'd0;
            sample_s[k][DATA_W-1:0] = data_in[k*DATA_W +: DATA_W];
        end
    end

    // Select the addressed channel's live sample and tracked extremes
    always_comb begin
        sel_live_s     = 12'd0;
        sel_max_s      = 12'd0;
        sel_min_s      = 12'd0;
        sel_valid_s    = 1'b0;
        sel_in_range_s = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            sel_live_s     = (sel_s == 4'(k)) ? sample_s[k] : sel_live_s;
            sel_max_s      = (sel_s == 4'(k)) ? max_q[k]    : sel_max_s;
            sel_min_s      = (sel_s == 4'(k)) ? min_q[k]    : sel_min_s;
            sel_valid_s    = (sel_s == 4'(k)) ? valid_q[k]  : sel_valid_s;
            sel_in_range_s = (sel_s == 4'(k)) ? 1'b1        : sel_in_range_s;
        end
    end

    // Mode decode; tracked modes read zero until the channel has a sample
    always_comb begin
        disp_d = 12'd0;
        case (mode_s)
            2'b00:   disp_d = sel_live_s;
            2'b01:   disp_d = sel_valid_s ? sel_max_s : 12'd0;
            2'b10:   disp_d = sel_valid_s ? sel_min_s : 12'd0;
            2'b11:   disp_d = sel_valid_s ? (sel_max_s - sel_min_s) : 12'd0;
            default: disp_d = 12'd0;
        endcase
    end

    assign change_s = (sel_s != sel_prev_q) || (mode_s != mode_prev_q);
    assign tick_s   = (cnt_q == CNT_W'(0));
    assign load_s   = (tick_s || change_s) && !freeze_s;

    // Refresh counter; a selection change restarts it so the forced load counts as a tick
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (change_s) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_d = CNT_W'(0);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Switch synchroniser, change tracking and refresh counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_meta_q   <= 10'd0;
            sw_sync_q   <= 10'd0;
            sel_prev_q  <= 4'd0;
            mode_prev_q <= 2'd0;
            cnt_q       <= CNT_W'(0);
        end else begin
            sw_meta_q   <= SW_in;
            sw_sync_q   <= sw_meta_q;
            sel_prev_q  <= sel_s;
            mode_prev_q <= mode_s;
            cnt_q       <= cnt_d;
        end
    end

    // Per-channel max/min capture; clear takes priority over the incoming sample
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                max_q[k] <= 12'd0;
                min_q[k] <= 12'hFFF;
            end
            valid_q <= '0;
        end else if (clear_s) begin
            for (int k = 0; k < NUM_CH; k++) begin
                max_q[k] <= 12'd0;
                min_q[k] <= 12'hFFF;
            end
            valid_q <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                max_q[k] <= (sample_s[k] > max_q[k]) ? sample_s[k] : max_q[k];
                min_q[k] <= (sample_s[k] < min_q[k]) ? sample_s[k] : min_q[k];
            end
            valid_q <= '1;
        end
    end

    // Display register and segment outputs, one cycle behind the display register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_q <= 12'd0;
            dash_q <= 1'b0;
            hex1_q <= 8'hFF;
            hex2_q <= 8'hFF;
            hex3_q <= 8'hFF;
        end else begin
            if (load_s) begin
                disp_q <= disp_d;
                dash_q <= !sel_in_range_s;
            end else begin
                disp_q <= disp_q;
                dash_q <= dash_q;
            end
            if (dash_q) begin
                hex1_q <= 8'hBF;
                hex2_q <= 8'hBF;
                hex3_q <= {!freeze_s, 7'h3F};
            end else begin
                hex1_q <= {1'b1, hex_seg(disp_q[3:0])};
                hex2_q <= {1'b1, hex_seg(disp_q[7:4])};
                hex3_q <= {!freeze_s, hex_seg(disp_q[11:8])};
            end
        end
    end

    assign HEX1_in = hex1_q;
    assign HEX2_in = hex2_q;
    assign HEX3_in = hex3_q;

endmodule

// File: tb/tb_lnvd_view_nsig_capture.sv
// Directed bench for lnvd_view_nsig_capture: live, peak, clear, freeze, out-of-range and reset cases.
module tb_lnvd_view_nsig_capture;

    localparam int NUM_CH = 8;
    localparam int DATA_W = 12;

    logic                     clk;
    logic                     reset_n;
    logic [9:0]               SW_in;
    logic [NUM_CH*DATA_W-1:0] data_in;
    logic [7:0]               HEX1_in;
    logic [7:0]               HEX2_in;
    logic [7:0]               HEX3_in;

    int n_total;
    int n_bad;

    lnvd_view_nsig_capture #(
        .NUM_CH      (NUM_CH),
        .DATA_W      (DATA_W),
        .REFRESH_DIV (64)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .SW_in   (SW_in),
        .data_in (data_in),
        .HEX1_in (HEX1_in),
        .HEX2_in (HEX2_in),
        .HEX3_in (HEX3_in)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check_val(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ch(input int k, input logic [11:0] v);
        data_in[k*DATA_W +: DATA_W] = v;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset_n = 1'b0;
        SW_in   = 10'h000;
        data_in = '0;
        set_ch(1, 12'h7C3);
        set_ch(2, 12'h010);
        set_ch(3, 12'h0A5);
        wait_cyc(3);
        check_val("reset_blank", {HEX3_in, HEX2_in, HEX1_in}, 24'hFFFFFF);

        reset_n = 1'b1;
        wait_cyc(2);
        check_val("post_reset_000", {HEX3_in, HEX2_in, HEX1_in}, 24'hC0C0C0);

        // ch2 sees 0x010, 0xF0, then holds 0x030
        set_ch(2, 12'h0F0);
        wait_cyc(1);
        set_ch(2, 12'h030);

        SW_in = 10'h003;
        wait_cyc(5);
        check_val("live_ch3", {HEX3_in, HEX2_in, HEX1_in}, 24'hC08892);

        SW_in = 10'h012;
        wait_cyc(5);
        check_val("max_ch2", {HEX3_in, HEX2_in, HEX1_in}, 24'hC08EC0);
        SW_in = 10'h022;
        wait_cyc(5);
        check_val("min_ch2", {HEX3_in, HEX2_in, HEX1_in}, 24'hC0F9C0);
        SW_in = 10'h032;
        wait_cyc(5);
        check_val("pp_ch2", {HEX3_in, HEX2_in, HEX1_in}, 24'hC086C0);

        // One-cycle clear pulse, then ch2 recaptures a steady 0x030
        SW_in = 10'h0B2;
        wait_cyc(1);
        SW_in = 10'h032;
        wait_cyc(80);
        check_val("clr_pp", {HEX3_in, HEX2_in, HEX1_in}, 24'hC0C0C0);
        SW_in = 10'h012;
        wait_cyc(5);
        check_val("clr_max", {HEX3_in, HEX2_in, HEX1_in}, 24'hC0B0C0);
        SW_in = 10'h022;
        wait_cyc(5);
        check_val("clr_min", {HEX3_in, HEX2_in, HEX1_in}, 24'hC0B0C0);

        // Clear held: samples ignored, max mode reads zero
        SW_in = 10'h092;
        wait_cyc(80);
        check_val("clr_held_max", {HEX3_in, HEX2_in, HEX1_in}, 24'hC0C0C0);
        SW_in = 10'h012;
        wait_cyc(80);
        check_val("clr_release_max", {HEX3_in, HEX2_in, HEX1_in}, 24'hC0B0C0);

        set_ch(0, 12'h111);
        SW_in = 10'h000;
        wait_cyc(5);
        check_val("live_ch0", {HEX3_in, HEX2_in, HEX1_in}, 24'hF9F9F9);
        SW_in = 10'h040;
        wait_cyc(4);
        check_val("freeze_dp", {HEX3_in, HEX2_in, HEX1_in}, 24'h79F9F9);
        set_ch(0, 12'h222);
        wait_cyc(150);
        check_val("freeze_hold", {HEX3_in, HEX2_in, HEX1_in}, 24'h79F9F9);
        SW_in = 10'h000;
        wait_cyc(80);
        check_val("unfreeze", {HEX3_in, HEX2_in, HEX1_in}, 24'hA4A4A4);

        SW_in = 10'h039;
        wait_cyc(5);
        check_val("dash_sel9", {HEX3_in, HEX2_in, HEX1_in}, 24'hBFBFBF);
        SW_in = 10'h008;
        wait_cyc(6);
        check_val("dash_sel8", {HEX3_in, HEX2_in, HEX1_in}, 24'hBFBFBF);
        // Counter just restarted, so only the forced load can update within this window
        SW_in = 10'h001;
        wait_cyc(4);
        check_val("sel_ch1_fast", {HEX3_in, HEX2_in, HEX1_in}, 24'hF8C6B0);

        SW_in = 10'h032;
        set_ch(2, 12'hFF0);
        wait_cyc(5);
        set_ch(2, 12'h030);
        wait_cyc(1);
        reset_n = 1'b0;
        #1;
        check_val("midrun_reset_blank", {HEX3_in, HEX2_in, HEX1_in}, 24'hFFFFFF);
        SW_in = 10'h012;
        wait_cyc(2);
        reset_n = 1'b1;
        wait_cyc(6);
        check_val("reset_discards_max", {HEX3_in, HEX2_in, HEX1_in}, 24'hC0B0C0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
